// File: rtl/hamming_pkg.sv
// Shared constants, FSM state type and data-extraction helper for the
// Hamming(15,11) serial receive path.
package hamming_pkg;

  localparam int N_CODE = 15;
  localparam int N_DATA = 11;
  localparam int N_SYN  = 4;

  localparam int PARITY_IDX [4] = '{0, 1, 3, 7};

  typedef enum logic [1:0] {
    SHIFT   = 2'd0,
    CORRECT = 2'd1,
    OUT     = 2'd2
  } state_t;

  // Non-parity indices in ascending order land LSB-first: c2 -> bit 0 ... c14 -> bit 10.
  function automatic logic [N_DATA-1:0] extract_data(input logic [N_CODE-1:0] c);
    logic [N_DATA-1:0] d;
    logic              is_par;
    int                k;
    d = '0;
    k = 0;
    for (int i = 0; i < N_CODE; i++) begin
      is_par = 1'b0;
      for (int p = 0; p < 4; p++) begin
        if (PARITY_IDX[p] == i) is_par = 1'b1;
      end
      if (!is_par) begin
        d[k] = c[i];
        k++;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/hamming_fix.sv
// Single-error corrector: flips codeword index syn-1 when syn is nonzero.
// Purely combinational, no backpressure.
module hamming_fix
  import hamming_pkg::*;
(
  input  logic [N_CODE-1:0] code,
  input  logic [N_SYN-1:0]  syn,
  output logic [N_CODE-1:0] fixed
);

  always_comb begin
    fixed = code;
    for (int i = 0; i < N_CODE; i++) begin
      if (syn == N_SYN'(i + 1)) fixed[i] = ~code[i];
    end
  end

endmodule

// File: rtl/hamming_serial_rx.sv
// Bit-serial Hamming(15,11) receiver: syndrome accumulated per bit, one CORRECT cycle,
// word then held on out_* until out_ready; bit_ready is low from last bit until handshake.
module hamming_serial_rx
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_sof,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic [N_DATA-1:0] out_data,
  output logic [N_SYN-1:0]  out_syn,
  output logic              out_corr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              abort_pulse,
  input  logic              clr_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam logic [3:0] LAST_IDX = 4'(N_CODE - 1);

  state_t              state_q, state_d;
  logic [3:0]          idx_q;
  logic [N_SYN-1:0]    syn_q;
  logic [N_CODE-1:0]   code_q;
  logic [N_CODE-1:0]   code_fixed;
  logic                accept;
  logic                sof_restart;
  logic                cnt_inc;

  assign accept      = bit_valid && bit_ready;
  assign sof_restart = accept && bit_sof && (idx_q != 4'd0);
  assign cnt_inc     = (state_q == CORRECT) && (syn_q != '0);

  hamming_fix u_fix (
    .code  (code_q),
    .syn   (syn_q),
    .fixed (code_fixed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SHIFT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SHIFT:   if (accept && !sof_restart && idx_q == LAST_IDX) state_d = CORRECT;
      CORRECT: state_d = OUT;
      OUT:     if (out_ready) state_d = SHIFT;
      default: state_d = SHIFT;
    endcase
  end

  always_comb begin
    bit_ready = (state_q == SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      syn_q       <= '0;
      code_q      <= '0;
      out_data    <= '0;
      out_syn     <= '0;
      out_corr    <= 1'b0;
      out_valid   <= 1'b0;
      abort_pulse <= 1'b0;
    end else begin
      abort_pulse <= sof_restart;
      if (accept) begin
        // A mid-frame sof restarts the frame with this bit as index 0.
        if (sof_restart) begin
          code_q <= {{(N_CODE-1){1'b0}}, bit_in};
          syn_q  <= {{(N_SYN-1){1'b0}}, bit_in};
          idx_q  <= 4'd1;
        end else begin
          code_q[idx_q] <= bit_in;
          if (bit_in) syn_q <= syn_q ^ (idx_q + 4'd1);
          idx_q <= (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;
        end
      end
      if (state_q == CORRECT) begin
        out_data  <= extract_data(code_fixed);
        out_syn   <= syn_q;
        out_corr  <= (syn_q != '0);
        out_valid <= 1'b1;
      end
      if (state_q == OUT && out_ready) begin
        out_valid <= 1'b0;
        syn_q     <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr_count) begin
      err_count <= cnt_inc ? CNT_W'(1) : '0;
    end else if (cnt_inc && err_count != {CNT_W{1'b1}}) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Directed-vector bench for hamming_serial_rx with a 2-bit error counter.
module tb_hamming_serial_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bit_in, bit_sof, bit_valid, bit_ready;
  logic [10:0] out_data;
  logic [3:0]  out_syn;
  logic        out_corr, out_valid, out_ready;
  logic        abort_pulse, clr_count;
  logic [1:0]  err_count;

  int n_vec = 0;
  int n_bad = 0;
  int n_abort = 0;
  int a0;

  hamming_serial_rx #(.CNT_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_in      (bit_in),
    .bit_sof     (bit_sof),
    .bit_valid   (bit_valid),
    .bit_ready   (bit_ready),
    .out_data    (out_data),
    .out_syn     (out_syn),
    .out_corr    (out_corr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .abort_pulse (abort_pulse),
    .clr_count   (clr_count),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (abort_pulse === 1'b1) n_abort++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic send_bits(input logic [14:0] code, input int n, input logic sof_first);
    for (int i = 0; i < n; i++) begin
      bit_in    = code[i];
      bit_sof   = (i == 0) && sof_first;
      bit_valid = 1'b1;
      @(posedge clk); #1;
    end
    bit_valid = 1'b0;
    bit_sof   = 1'b0;
  endtask

  // Called #1 after the edge accepting bit 14; the CORRECT cycle is one clock.
  task automatic expect_word(input string tag, input logic [10:0] d, input logic [3:0] s,
                             input logic c, input logic [1:0] cnt);
    int lat;
    lat = 0;
    chk({tag, "_valid_in_correct"}, out_valid, 0);
    while (out_valid !== 1'b1 && lat < 6) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 1);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_syn"}, out_syn, s);
    chk({tag, "_corr"}, out_corr, c);
    chk({tag, "_cnt"}, err_count, cnt);
  endtask

  task automatic handshake(input string tag);
    @(posedge clk); #1;
    chk({tag, "_valid_clr"}, out_valid, 0);
    chk({tag, "_ready_back"}, bit_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; bit_in = 1'b0; bit_sof = 1'b0; bit_valid = 1'b0;
    out_ready = 1'b1; clr_count = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_ready", bit_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_syn", out_syn, 0);
    chk("rst_corr", out_corr, 0);
    chk("rst_abort", abort_pulse, 0);
    chk("rst_cnt", err_count, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean codeword: positions 1,2,3 set, syndrome 1^2^3 = 0, data bit c2.
    send_bits(15'h0007, 15, 1'b1);
    chk("clean_ready_low", bit_ready, 0);
    expect_word("clean", 11'h001, 4'h0, 1'b0, 2'd0);
    handshake("clean");

    // Index 10 flipped: syndrome 11.
    send_bits(15'h0407, 15, 1'b1);
    expect_word("fix10", 11'h001, 4'hB, 1'b1, 2'd1);
    handshake("fix10");

    // Stall: bits driven while OUT must be ignored.
    out_ready = 1'b0;
    send_bits(15'h0040, 15, 1'b1);
    expect_word("stall", 11'h000, 4'h7, 1'b1, 2'd2);
    for (int c = 0; c < 5; c++) begin
      bit_valid = 1'b1; bit_in = 1'b1; bit_sof = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("stall%0d_valid", c), out_valid, 1);
      chk($sformatf("stall%0d_ready", c), bit_ready, 0);
      chk($sformatf("stall%0d_data", c), out_data, 11'h000);
      chk($sformatf("stall%0d_syn", c), out_syn, 4'h7);
    end
    bit_valid = 1'b0; bit_sof = 1'b0;
    out_ready = 1'b1;
    handshake("stall");
    chk("abort_none_yet", n_abort, 0);

    // Partial frame of 6 bits discarded by a fresh sof.
    a0 = n_abort;
    send_bits(15'h7FFF, 6, 1'b0);
    send_bits(15'h0007, 15, 1'b1);
    expect_word("abort", 11'h001, 4'h0, 1'b0, 2'd2);
    handshake("abort");
    chk("abort_pulses", n_abort - a0, 1);

    // Counter saturation at 3, then clear coincident with an increment.
    send_bits(15'h0407, 15, 1'b1);
    expect_word("sat1", 11'h001, 4'hB, 1'b1, 2'd3);
    handshake("sat1");
    send_bits(15'h0407, 15, 1'b1);
    expect_word("sat2", 11'h001, 4'hB, 1'b1, 2'd3);
    handshake("sat2");
    send_bits(15'h0407, 15, 1'b1);
    clr_count = 1'b1;
    expect_word("clrinc", 11'h001, 4'hB, 1'b1, 2'd1);
    clr_count = 1'b0;
    handshake("clrinc");
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    chk("clr_alone", err_count, 0);
    send_bits(15'h0407, 15, 1'b1);
    expect_word("pre_rst", 11'h001, 4'hB, 1'b1, 2'd1);
    handshake("pre_rst");

    // Asynchronous reset while the 10th bit is on the line.
    a0 = n_abort;
    send_bits(15'h0407, 9, 1'b1);
    bit_valid = 1'b1; bit_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", bit_ready, 1);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_cnt", err_count, 0);
    chk("midrst_abort", abort_pulse, 0);
    bit_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_bits(15'h0407, 15, 1'b1);
    expect_word("post_rst", 11'h001, 4'hB, 1'b1, 2'd1);
    handshake("post_rst");
    chk("post_rst_abort", n_abort - a0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
